// File: rtl/controle_multiciclo_if.sv
// Bundle between the multicycle control unit and the datapath: fetched instruction in,
// FSM state, ALU controls, register addresses and strobes out.
interface controle_multiciclo_if;
    logic [31:0] instrucao;
    logic [3:0]  estado;
    logic        alusrc;
    logic [3:0]  alucontrol;
    logic [31:0] immediate;
    logic        negativo;
    logic        branch;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        pcwrite;
    logic        erro;

    modport master (
        input  instrucao,
        output estado, alusrc, alucontrol, immediate, negativo, branch,
        output rs1, rs2, rd,
        output regwrite, memread, memwrite, memtoreg, pcwrite, erro
    );

    modport slave (
        output instrucao,
        input  estado, alusrc, alucontrol, immediate, negativo, branch,
        input  rs1, rs2, rd,
        input  regwrite, memread, memwrite, memtoreg, pcwrite, erro
    );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle RISC-V control FSM with immediate generator; every output comes from a register,
// so nothing on the instruction bus reaches the ALU controls combinationally.
module controle_multiciclo (
    input  logic                  clk,
    input  logic                  rst_n,
    controle_multiciclo_if.master bus
);

    typedef enum logic [3:0] {
        INICIO      = 4'b0000,
        BUSCA       = 4'b0001,
        DECODIFICA  = 4'b0010,
        EXEC_R      = 4'b0101,
        EXEC_I      = 4'b0110,
        MEM_LE      = 4'b0111,
        MEM_ESCREVE = 4'b1000,
        ESCRITA     = 4'b1001,
        ATUALIZA_PC = 4'b1010,
        ERRO        = 4'b1111
    } estado_t;

    typedef enum logic [2:0] {
        C_ALU,
        C_LW,
        C_SW,
        C_BR,
        C_ILEGAL
    } classe_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // Absolute value of a sign-extended field; the most negative B-type value still fits.
    function automatic logic [31:0] magnitude(input logic signed [31:0] v);
        logic signed [31:0] m;
        m = v[31] ? -v : v;
        return m;
    endfunction

    estado_t     state_q, state_d;
    classe_t     classe_q;
    logic [31:0] ir_q;

    logic        alusrc_q;
    logic [3:0]  aluctl_q;
    logic [31:0] imm_q;
    logic        neg_q;

    logic        regwrite_q, regwrite_d;
    logic        memread_q, memread_d;
    logic        memwrite_q, memwrite_d;
    logic        memtoreg_q, memtoreg_d;
    logic        pcwrite_q, pcwrite_d;
    logic        branch_q, branch_d;
    logic        erro_q, erro_d;

    // Instruction fields
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic signed [31:0] imm_i_s;
    logic signed [31:0] imm_s_s;
    logic signed [31:0] imm_b_s;

    assign opcode  = ir_q[6:0];
    assign funct3  = ir_q[14:12];
    assign funct7  = ir_q[31:25];
    assign imm_i_s = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b_s = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

    classe_t     dec_classe;
    logic        dec_tipo_r;
    logic        dec_alusrc;
    logic [3:0]  dec_aluctl;
    logic [31:0] dec_imm;
    logic        dec_neg;

    // Decoder over the instruction register; only meaningful while in DECODIFICA.
    always_comb begin
        dec_classe = C_ILEGAL;
        dec_tipo_r = 1'b0;
        dec_alusrc = 1'b0;
        dec_aluctl = 4'b0000;
        dec_imm    = 32'd0;
        dec_neg    = 1'b0;
        case (opcode)
            OP_R: begin
                dec_tipo_r = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE) begin
                            dec_classe = C_ALU;
                            dec_aluctl = 4'b0010;
                        end else if (funct7 == F7_SUB) begin
                            dec_classe = C_ALU;
                            dec_aluctl = 4'b0110;
                        end
                    end
                    3'b100: if (funct7 == F7_BASE) begin
                        dec_classe = C_ALU;
                        dec_aluctl = 4'b0100;
                    end
                    3'b101: if (funct7 == F7_BASE) begin
                        dec_classe = C_ALU;
                        dec_aluctl = 4'b0101;
                    end
                    3'b110: if (funct7 == F7_BASE) begin
                        dec_classe = C_ALU;
                        dec_aluctl = 4'b0001;
                    end
                    3'b111: if (funct7 == F7_BASE) begin
                        dec_classe = C_ALU;
                        dec_aluctl = 4'b0000;
                    end
                    default: dec_classe = C_ILEGAL;
                endcase
            end
            OP_IMM: if (funct3 == 3'b000) begin
                dec_classe = C_ALU;
                dec_alusrc = 1'b1;
                dec_aluctl = 4'b0011;
                dec_imm    = magnitude(imm_i_s);
                dec_neg    = ir_q[31];
            end
            OP_LOAD: if (funct3 == 3'b010) begin
                dec_classe = C_LW;
                dec_alusrc = 1'b1;
                dec_aluctl = 4'b0010;
                dec_imm    = magnitude(imm_i_s);
                dec_neg    = ir_q[31];
            end
            OP_STORE: if (funct3 == 3'b010) begin
                dec_classe = C_SW;
                dec_alusrc = 1'b1;
                dec_aluctl = 4'b0010;
                dec_imm    = magnitude(imm_s_s);
                dec_neg    = ir_q[31];
            end
            OP_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b001) begin
                dec_classe = C_BR;
                dec_alusrc = 1'b1;
                dec_aluctl = (funct3 == 3'b000) ? 4'b0110 : 4'b1111;
                dec_imm    = magnitude(imm_b_s);
                dec_neg    = ir_q[31];
            end
            default: dec_classe = C_ILEGAL;
        endcase
    end

    // Next state, and the Moore strobes for the state being entered so they register in step with it
    always_comb begin
        state_d    = state_q;
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        pcwrite_d  = 1'b0;
        branch_d   = 1'b0;
        erro_d     = 1'b0;

        case (state_q)
            INICIO:     state_d = BUSCA;
            BUSCA:      state_d = DECODIFICA;
            DECODIFICA: begin
                if (dec_classe == C_ILEGAL) begin
                    state_d = ERRO;
                end else if (dec_tipo_r) begin
                    state_d = EXEC_R;
                end else begin
                    state_d = EXEC_I;
                end
            end
            EXEC_R, EXEC_I: begin
                case (classe_q)
                    C_LW:    state_d = MEM_LE;
                    C_SW:    state_d = MEM_ESCREVE;
                    C_BR:    state_d = ATUALIZA_PC;
                    default: state_d = ESCRITA;
                endcase
            end
            MEM_LE:      state_d = ESCRITA;
            MEM_ESCREVE: state_d = ATUALIZA_PC;
            ESCRITA:     state_d = ATUALIZA_PC;
            ATUALIZA_PC: state_d = BUSCA;
            ERRO:        state_d = ERRO;
            default:     state_d = INICIO;
        endcase

        regwrite_d = (state_d == ESCRITA);
        memtoreg_d = (state_d == ESCRITA) && (classe_q == C_LW);
        memread_d  = (state_d == MEM_LE);
        memwrite_d = (state_d == MEM_ESCREVE);
        pcwrite_d  = (state_d == ATUALIZA_PC);
        branch_d   = (state_d == ATUALIZA_PC) && (classe_q == C_BR);
        erro_d     = (state_d == ERRO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= INICIO;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            pcwrite_q  <= 1'b0;
            branch_q   <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            pcwrite_q  <= pcwrite_d;
            branch_q   <= branch_d;
            erro_q     <= erro_d;
        end
    end

    // IR captures on the edge leaving BUSCA; ALU controls on the edge leaving DECODIFICA
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_q     <= 32'd0;
            classe_q <= C_ALU;
            alusrc_q <= 1'b0;
            aluctl_q <= 4'b0000;
            imm_q    <= 32'd0;
            neg_q    <= 1'b0;
        end else begin
            if (state_q == BUSCA) begin
                ir_q <= bus.instrucao;
            end
            if (state_q == DECODIFICA) begin
                classe_q <= dec_classe;
                alusrc_q <= dec_alusrc;
                aluctl_q <= dec_aluctl;
                imm_q    <= dec_imm;
                neg_q    <= dec_neg;
            end
        end
    end

    // Register addresses are slices of IR, so they share its load edge and its reset.
    assign bus.rs1        = ir_q[19:15];
    assign bus.rs2        = ir_q[24:20];
    assign bus.rd         = ir_q[11:7];

    assign bus.estado     = state_q;
    assign bus.alusrc     = alusrc_q;
    assign bus.alucontrol = aluctl_q;
    assign bus.immediate  = imm_q;
    assign bus.negativo   = neg_q;
    assign bus.branch     = branch_q;
    assign bus.regwrite   = regwrite_q;
    assign bus.memread    = memread_q;
    assign bus.memwrite   = memwrite_q;
    assign bus.memtoreg   = memtoreg_q;
    assign bus.pcwrite    = pcwrite_q;
    assign bus.erro       = erro_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: a per-instruction expectation model fills a queue of
// per-cycle output records, a negedge process compares them, and directed checks pin key points.
module tb_controle_multiciclo;

    logic clk = 1'b0;
    logic rst_n;

    controle_multiciclo_if bus ();

    controle_multiciclo dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  estado;
        logic        chk_alu;
        logic        alusrc;
        logic [3:0]  aluctl;
        logic [31:0] imm;
        logic        neg;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        pcwrite;
        logic        branch;
        logic        erro;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Values that persist across instructions in the model
    logic [4:0]  p_rs1 = 5'd0, p_rs2 = 5'd0, p_rd = 5'd0;
    logic        p_src = 1'b0, p_neg = 1'b0;
    logic [3:0]  p_ctl = 4'd0;
    logic [31:0] p_imm = 32'd0;

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, act, req, $time);
        end
    endtask

    function automatic int sext(input int v, input int bits);
        int lim;
        lim = 1 << (bits - 1);
        return (v >= lim) ? v - (lim * 2) : v;
    endfunction

    // Spec-level model: from one instruction word, the state walk and outputs for every cycle it occupies.
    task automatic model_push(input logic [31:0] instr, output int ncyc);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          val;
        int          kind;
        logic        src, neg;
        logic [3:0]  ctl;
        logic [31:0] imm;
        int          st[$];
        exp_t        r;
        op = instr[6:0]; f3 = instr[14:12]; f7 = instr[31:25];
        kind = 5; src = 1'b1; ctl = 4'd0; val = 0;
        if (op == 7'h33) begin
            src = 1'b0;
            if (f3 == 3'd0 && f7 == 7'h00)      begin kind = 0; ctl = 4'd2; end
            else if (f3 == 3'd0 && f7 == 7'h20) begin kind = 0; ctl = 4'd6; end
            else if (f7 == 7'h00 && f3 == 3'd4) begin kind = 0; ctl = 4'd4; end
            else if (f7 == 7'h00 && f3 == 3'd5) begin kind = 0; ctl = 4'd5; end
            else if (f7 == 7'h00 && f3 == 3'd6) begin kind = 0; ctl = 4'd1; end
            else if (f7 == 7'h00 && f3 == 3'd7) begin kind = 0; ctl = 4'd0; end
        end else if (op == 7'h13 && f3 == 3'd0) begin
            kind = 1; ctl = 4'd3; val = sext(int'(instr[31:20]), 12);
        end else if (op == 7'h03 && f3 == 3'd2) begin
            kind = 2; ctl = 4'd2; val = sext(int'(instr[31:20]), 12);
        end else if (op == 7'h23 && f3 == 3'd2) begin
            kind = 3; ctl = 4'd2; val = sext(int'({instr[31:25], instr[11:7]}), 12);
        end else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
            kind = 4; ctl = (f3 == 3'd0) ? 4'd6 : 4'd15;
            val = sext(int'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}), 13);
        end
        imm = 32'((val < 0) ? -val : val);
        neg = (kind == 0) ? 1'b0 : instr[31];
        case (kind)
            0:       st = '{1, 2, 5, 9, 10};
            1:       st = '{1, 2, 6, 9, 10};
            2:       st = '{1, 2, 6, 7, 9, 10};
            3:       st = '{1, 2, 6, 8, 10};
            4:       st = '{1, 2, 6, 10};
            default: begin
                st = '{1, 2};
                for (int i = 0; i < 20; i++) st.push_back(15);
            end
        endcase
        for (int c = 0; c < st.size(); c++) begin
            r.estado   = 4'(st[c]);
            r.chk_alu  = (st[c] != 15);
            r.rs1      = (c == 0) ? p_rs1 : instr[19:15];
            r.rs2      = (c == 0) ? p_rs2 : instr[24:20];
            r.rd       = (c == 0) ? p_rd  : instr[11:7];
            r.alusrc   = (c < 2) ? p_src : src;
            r.aluctl   = (c < 2) ? p_ctl : ctl;
            r.imm      = (c < 2) ? p_imm : imm;
            r.neg      = (c < 2) ? p_neg : neg;
            r.regwrite = (st[c] == 9);
            r.memtoreg = (st[c] == 9) && (kind == 2);
            r.memread  = (st[c] == 7);
            r.memwrite = (st[c] == 8);
            r.pcwrite  = (st[c] == 10);
            r.branch   = (st[c] == 10) && (kind == 4);
            r.erro     = (st[c] == 15);
            exp_q.push_back(r);
        end
        p_rs1 = instr[19:15]; p_rs2 = instr[24:20]; p_rd = instr[11:7];
        p_src = src; p_ctl = ctl; p_imm = imm; p_neg = neg;
        ncyc = st.size();
    endtask

    always @(negedge clk) begin
        exp_t r;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            check("estado",   32'(bus.estado),   32'(r.estado));
            check("rs1",      32'(bus.rs1),      32'(r.rs1));
            check("rs2",      32'(bus.rs2),      32'(r.rs2));
            check("rd",       32'(bus.rd),       32'(r.rd));
            check("regwrite", 32'(bus.regwrite), 32'(r.regwrite));
            check("memtoreg", 32'(bus.memtoreg), 32'(r.memtoreg));
            check("memread",  32'(bus.memread),  32'(r.memread));
            check("memwrite", 32'(bus.memwrite), 32'(r.memwrite));
            check("pcwrite",  32'(bus.pcwrite),  32'(r.pcwrite));
            check("branch",   32'(bus.branch),   32'(r.branch));
            check("erro",     32'(bus.erro),     32'(r.erro));
            if (r.chk_alu) begin
                check("alusrc",     32'(bus.alusrc),     32'(r.alusrc));
                check("alucontrol", 32'(bus.alucontrol), 32'(r.aluctl));
                check("immediate",  bus.immediate,       r.imm);
                check("negativo",   32'(bus.negativo),   32'(r.neg));
            end
        end
    end

    // Literal expectations at fixed points of the directed program
    task automatic pin(input int k, input int c);
        if (k == 0 && c == 2) begin
            check("add_estado", 32'(bus.estado), 32'd5);
            check("add_ctl",    32'(bus.alucontrol), 32'h2);
            check("add_rd",     32'(bus.rd), 32'd3);
        end
        if (k == 0 && c == 3) check("add_regwrite", 32'(bus.regwrite), 32'd1);
        if (k == 1 && c == 2) begin
            check("lw_imm", bus.immediate, 32'd8);
            check("lw_neg", 32'(bus.negativo), 32'd1);
        end
        if (k == 1 && c == 3) check("lw_memread", 32'(bus.memread), 32'd1);
        if (k == 1 && c == 4) check("lw_memtoreg", 32'(bus.memtoreg), 32'd1);
        if (k == 2 && c == 3) check("sw_memwrite", 32'(bus.memwrite), 32'd1);
        if (k == 3 && c == 3) begin
            check("bne_branch", 32'(bus.branch), 32'd1);
            check("bne_imm",    bus.immediate, 32'd4);
            check("bne_ctl",    32'(bus.alucontrol), 32'hF);
        end
        if (k == 4 && c == 2) check("addi_min_imm", bus.immediate, 32'd2048);
        if (k == 7 && c == 2) check("beq_min_imm", bus.immediate, 32'd4096);
    endtask

    logic [31:0] prog[9];
    int          ncyc;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        prog = '{32'h002081B3,   // add  x3,x1,x2
                 32'hFF812283,   // lw   x5,-8(x2)
                 32'h00502623,   // sw   x5,12(x0)
                 32'hFE209EE3,   // bne  x1,x2,-4
                 32'h80000093,   // addi x1,x0,-2048
                 32'h40208233,   // sub  x4,x1,x2
                 32'h0020D2B3,   // srl  x5,x1,x2
                 32'h80000063,   // beq  x0,x0,-4096
                 32'h00000000};  // illegal
        rst_n = 1'b0;
        bus.instrucao = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_estado",   32'(bus.estado), 32'd0);
        check("rst_imm",      bus.immediate, 32'd0);
        check("rst_pcwrite",  32'(bus.pcwrite), 32'd0);

        exp_q.push_back('{estado: 4'd0, chk_alu: 1'b1, default: '0});
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 9; k++) begin
            bus.instrucao = prog[k];
            model_push(prog[k], ncyc);
            for (int c = 0; c < ncyc; c++) begin
                pin(k, c);
                @(posedge clk); #1;
            end
        end
        check("fila_vazia", 32'(exp_q.size()), 32'd0);
        check("erro_hold",  32'(bus.erro), 32'd1);

        // One-edge reset out of ERRO
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst2_estado", 32'(bus.estado), 32'd0);
        check("rst2_erro",   32'(bus.erro), 32'd0);
        check("rst2_alusrc", 32'(bus.alusrc), 32'd0);
        check("rst2_ctl",    32'(bus.alucontrol), 32'd0);
        check("rst2_rs2",    32'(bus.rs2), 32'd0);
        @(posedge clk); #1;
        check("rst2_busca", 32'(bus.estado), 32'd1);

        // Reset during MEM_LE of a lw
        bus.instrucao = 32'hFF812283;
        repeat (3) @(posedge clk);
        #1;
        check("mid_estado", 32'(bus.estado), 32'd7);
        check("mid_memread", 32'(bus.memread), 32'd1);
        rst_n = 1'b0;
        bus.instrucao = 32'h00000000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_estado",  32'(bus.estado), 32'd0);
        check("mid_rst_memread", 32'(bus.memread), 32'd0);
        check("mid_rst_imm",     bus.immediate, 32'd0);
        check("mid_rst_rs1",     32'(bus.rs1), 32'd0);
        for (int c = 0; c < 4; c++) begin
            check("mid_regwrite", 32'(bus.regwrite), 32'd0);
            @(posedge clk); #1;
        end
        check("mid_final_erro", 32'(bus.estado), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
